bound_relu_sched: RTL
=====================

BOUND_RELU_SCHED -- requirements
Module: bound_relu_sched

Interface
REQ-001 Parameters SHALL be D_BW (default 8, activation width), AB_BW (default 21, accumulator+bias width), CNT_BW (default 16, pixel counter width), PIPE_LAT (default 2, top_bound_relu input-to-output latency in cycles), FIFO_DEPTH (default 4, output buffer entries, SHALL be >= PIPE_LAT+1).
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 i_start  in  1  one-cycle layer start pulse.
REQ-005 i_bound_sel_cfg  in  2  bound select for the layer.
REQ-006 i_num_pix  in  CNT_BW  number of bias triples in the layer.
REQ-007 i_valid  in  1 / o_ready  out  1  upstream handshake.
REQ-008 i_acc_bias0..2  in  AB_BW each  signed upstream accumulator+bias words.
REQ-009 o_bound_en  out  1 / o_bound_sel  out  2 / o_acc_bias0..2  out  AB_BW each  drive the bound-ReLU datapath.
REQ-010 i_act_data0..2  in  D_BW each  signed datapath results.
REQ-011 o_valid  out  1 / i_ready  in  1 / o_act_data0..2  out  D_BW each  downstream handshake and data.
REQ-012 o_busy  out  1  layer in progress; o_done  out  1  one-cycle completion pulse.

Function
REQ-013 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN on i_start with i_num_pix>0; i_bound_sel_cfg and i_num_pix SHALL be latched at that edge.
REQ-015 IDLE->DONE on i_start with i_num_pix==0; no data accepted.
REQ-016 i_start SHALL be ignored in RUN, DRAIN, DONE.
REQ-017 Transfer occurs on a rising edge with i_valid&&o_ready; the accepted triple SHALL appear on o_acc_bias0..2 on the next cycle and hold until the next transfer.
REQ-018 o_ready SHALL be 1 only in RUN and only when (in-flight count + FIFO occupancy) < FIFO_DEPTH.
REQ-019 A PIPE_LAT+1 stage valid shift register SHALL track each transfer; when its tail bit is 1, i_act_data0..2 SHALL be written into the FIFO that cycle.
REQ-020 Accepted-count reaching the latched i_num_pix SHALL move RUN->DRAIN on the edge of the final transfer.
REQ-021 DRAIN->DONE when shift register is all-zero and FIFO is empty (last beat consumed).
REQ-022 DONE SHALL last exactly one cycle with o_done=1, then IDLE.
REQ-023 o_busy SHALL be 1 in RUN and DRAIN only.
REQ-024 o_bound_en SHALL be 1 in RUN and DRAIN; o_bound_sel SHALL equal the latched select in RUN/DRAIN and 2'b00 otherwise.
REQ-025 o_valid SHALL equal FIFO non-empty; pop on o_valid&&i_ready; simultaneous push and pop on a full FIFO SHALL not occur (guaranteed by REQ-018); push and pop in one cycle SHALL keep occupancy unchanged.
REQ-026 Output order SHALL equal input order; no beat dropped or duplicated under any i_ready pattern.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, counters, shift register and FIFO pointers to 0, and all outputs (o_ready, o_bound_en, o_bound_sel, o_acc_bias*, o_valid, o_act_data*, o_busy, o_done) to 0.
REQ-028 Reset mid-layer SHALL abandon the layer with no o_done pulse; in-flight data is discarded.

Configuration
REQ-029 With macro BRC_PERF_CNT_EN defined, port o_stall_cnt (out, CNT_BW) SHALL count cycles in RUN/DRAIN where (i_valid&&!o_ready) or (o_valid&&!i_ready), saturating at all-ones, cleared on accepted i_start and on reset.
REQ-030 Without BRC_PERF_CNT_EN, o_stall_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset 10 ns low, then i_start, sel=2'b00, num_pix=3, inputs (32,-190,120),(20,-33,70),(-10,67,30), i_valid and i_ready held 1 -> o_bound_en=1, three o_valid beats in order at PIPE_LAT+1 cycles after each transfer, o_done one cycle after last pop.
REQ-032 num_pix=4, sel=2'b10, i_ready=0 for 10 cycles -> o_ready drops after FIFO_DEPTH accepts; no data lost; release i_ready -> four beats in order, o_done.
REQ-033 i_start with num_pix=0 -> o_done next cycle, o_busy never 1, o_valid never 1.
REQ-034 Second i_start (sel=2'b11) during RUN -> ignored; o_bound_sel keeps first layer value until DONE.
REQ-035 rst_n low mid-RUN with 2 beats in flight -> all outputs 0 immediately, no o_done, next layer runs normally.
REQ-036 With BRC_PERF_CNT_EN: 5 cycles i_valid=1 with o_ready=0 due to i_ready=0 -> o_stall_cnt=5 (plus downstream stall cycles per REQ-029, counted once per cycle).

Source files
------------

// File: rtl/bound_relu_sched.sv
// bound_relu_sched: layer scheduler wrapped around a bound-ReLU datapath that has a
// fixed latency. It accepts i_num_pix accumulator+bias triples and drives them into
// the datapath. A valid shift register follows each triple through the datapath, and
// a small FIFO holds the results, so downstream back-pressure never drops a beat.
// Optional feature: define BRC_PERF_CNT_EN to add the o_stall_cnt port and its counter.

module bound_relu_sched #(
  parameter int D_BW       = 8,
  parameter int AB_BW      = 21,
  parameter int CNT_BW     = 16,
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [1:0]              i_bound_sel_cfg,
  input  logic [CNT_BW-1:0]       i_num_pix,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [AB_BW-1:0] i_acc_bias0,
  input  logic signed [AB_BW-1:0] i_acc_bias1,
  input  logic signed [AB_BW-1:0] i_acc_bias2,
  output logic                    o_bound_en,
  output logic [1:0]              o_bound_sel,
  output logic signed [AB_BW-1:0] o_acc_bias0,
  output logic signed [AB_BW-1:0] o_acc_bias1,
  output logic signed [AB_BW-1:0] o_acc_bias2,
  input  logic signed [D_BW-1:0]  i_act_data0,
  input  logic signed [D_BW-1:0]  i_act_data1,
  input  logic signed [D_BW-1:0]  i_act_data2,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [D_BW-1:0]  o_act_data0,
  output logic signed [D_BW-1:0]  o_act_data1,
  output logic signed [D_BW-1:0]  o_act_data2,
`ifdef BRC_PERF_CNT_EN
  output logic [CNT_BW-1:0]       o_stall_cnt,
`endif
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(PIPE_LAT + FIFO_DEPTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, next_state;
  logic [1:0]          sel_q;
  logic [CNT_BW-1:0]   num_pix_q;
  logic [CNT_BW-1:0]   accepted;
  logic [PIPE_LAT:0]   vsr;
  logic [3*D_BW-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0]    occ;
  logic [SUM_W-1:0]    load;
  logic                start_ok, xfer, last_xfer, push, pop, room;

  assign start_ok  = (state == IDLE) && i_start;
  assign o_ready   = (state == RUN) && room;
  assign xfer      = i_valid && o_ready;
  assign last_xfer = (accepted + CNT_BW'(1)) == num_pix_q;
  assign push      = vsr[PIPE_LAT];
  assign o_valid   = (occ != '0);
  assign pop       = o_valid && i_ready;

  // Beats in the datapath plus beats in the FIFO. Every one of them needs a FIFO slot.
  always_comb begin
    load = SUM_W'(occ);
    for (int k = 0; k <= PIPE_LAT; k++) load = load + SUM_W'(vsr[k]);
    room = load < SUM_W'(FIFO_DEPTH);
  end

  // State register and layer configuration latched when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 2'b00;
      num_pix_q <= '0;
      accepted  <= '0;
    end else begin
      state <= next_state;
      if (start_ok) begin
        sel_q     <= i_bound_sel_cfg;
        num_pix_q <= i_num_pix;
        accepted  <= '0;
      end else if (xfer) begin
        accepted <= accepted + CNT_BW'(1);
      end
    end
  end

  // Next-state logic and the outputs decoded from the state.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    next_state  = state;
    o_busy      = 1'b0;
    o_bound_en  = 1'b0;
    o_bound_sel = 2'b00;
    o_done      = 1'b0;
    case (state)
      IDLE:  if (i_start) next_state = (i_num_pix == '0) ? DONE : RUN;
      RUN: begin
        o_busy      = 1'b1;
        o_bound_en  = 1'b1;
        o_bound_sel = sel_q;
        if (xfer && last_xfer) next_state = DRAIN;
      end
      DRAIN: begin
        o_busy      = 1'b1;
        o_bound_en  = 1'b1;
        o_bound_sel = sel_q;
        if ((vsr == '0) && (occ == '0)) next_state = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Hold the triple from the last transfer for the datapath, and track that transfer through its latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_acc_bias0 <= '0;
      o_acc_bias1 <= '0;
      o_acc_bias2 <= '0;
      vsr         <= '0;
    end else begin
      vsr <= (vsr << 1) | (PIPE_LAT + 1)'(xfer);
      if (xfer) begin
        o_acc_bias0 <= i_acc_bias0;
        o_acc_bias1 <= i_acc_bias1;
        o_acc_bias2 <= i_acc_bias2;
      end
    end
  end

  // FIFO storage. Entries are only ever read after they have been written.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; occupancy gates every read, so stale contents never escape.
    if (push) mem[wr_ptr] <= {i_act_data2, i_act_data1, i_act_data0};
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign {o_act_data2, o_act_data1, o_act_data0} = o_valid ? mem[rd_ptr] : '0;

`ifdef BRC_PERF_CNT_EN
  logic stall;
  assign stall = o_busy && ((i_valid && !o_ready) || (o_valid && !i_ready));

  // Saturating count of cycles stalled on either side. It restarts with each accepted layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         o_stall_cnt <= '0;
    else if (start_ok)                  o_stall_cnt <= '0;
    else if (stall && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + CNT_BW'(1);
  end
`endif

endmodule
